// File: rtl/host_pkg.sv
// Shared encodings for the host access port: command opcodes, target channel
// indices, control-word bit positions and the controller state type.
package host_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CTRL  = 2'b11
  } op_e;

  localparam int TGT_ICACHE  = 0;
  localparam int TGT_DCACHE  = 1;
  localparam int TGT_REGFILE = 2;
  localparam int TGT_SPARE   = 3;

  // Control commands reuse the address field as a small flag word.
  localparam int CTRL_HALT_BIT    = 0;
  localparam int CTRL_CLR_ERR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    DRAIN = 2'b11
  } state_e;

endpackage

// File: rtl/rd_align_pipe.sv
// Delay line that carries read valid/last/channel tag for RD_LAT cycles so the
// tag lines up with the data coming back from the target memories.
module rd_align_pipe #(
  parameter int RD_LAT = 1,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             inflight_o
);

  logic             valid_q [RD_LAT];
  logic             last_q  [RD_LAT];
  logic [TAG_W-1:0] tag_q   [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      last_q[0]  <= in_valid_i & in_last_i;
      tag_q[0]   <= in_tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[RD_LAT-1];
  assign out_last_o  = last_q[RD_LAT-1];
  assign out_tag_o   = tag_q[RD_LAT-1];

  // The output stage is being delivered this cycle; only earlier stages still count as in flight.
  generate
    if (RD_LAT > 1) begin : g_inflight
      logic [RD_LAT-2:0] early_valid;
      for (genvar gi = 0; gi < RD_LAT - 1; gi++) begin : g_early
        assign early_valid[gi] = valid_q[gi];
      end
      assign inflight_o = |early_valid;
    end else begin : g_no_inflight
      assign inflight_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/host_access_port.sv
// Host-side access controller: turns loader commands into single or burst
// accesses on the CPU storage channels and holds the core while the host owns them.
module host_access_port
  import host_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_TGT  = 4,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(N_TGT)-1:0] cmd_tgt,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     wdata_valid,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     wdata_ready,
  output logic                     rdata_valid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rdata_last,
  output logic [N_TGT-1:0]         tgt_en,
  output logic                     tgt_we,
  output logic [ADDR_W-1:0]        tgt_addr,
  output logic [DATA_W-1:0]        tgt_wdata,
  input  logic [N_TGT*DATA_W-1:0]  tgt_rdata,
  output logic                     core_halt,
  output logic                     err
);

  localparam int TGT_W = $clog2(N_TGT);

  state_e            state_q, state_d;
  logic [TGT_W-1:0]  tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic              wr_beat;
  logic              rd_issue;
  logic              access;
  logic              last_beat;
  logic              set_err;
  logic              clr_err;
  logic              pipe_valid;
  logic              pipe_last;
  logic              pipe_inflight;
  logic [TGT_W-1:0]  pipe_tag;
  logic [DATA_W-1:0] chan_rdata [N_TGT];

  assign wr_beat   = (state_q == WRITE) && wdata_valid;
  assign rd_issue  = (state_q == READ);
  assign access    = wr_beat || rd_issue;
  assign last_beat = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    set_err = 1'b0;
    clr_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_WRITE, OP_READ: begin
              tgt_d   = cmd_tgt;
              addr_d  = cmd_addr;
              cnt_d   = cmd_len;
              halt_d  = 1'b1;
              state_d = (op_e'(cmd_op) == OP_WRITE) ? WRITE : READ;
              // Unmapped channels still run the burst so the host protocol stays in step.
              set_err = (int'(cmd_tgt) >= N_TGT);
            end
            OP_CTRL: begin
              halt_d  = cmd_addr[CTRL_HALT_BIT];
              clr_err = cmd_addr[CTRL_CLR_ERR_BIT];
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      READ: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_beat) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (!pipe_inflight) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wdata_valid && (state_q != WRITE)) begin
      set_err = 1'b1;
    end
    err_d = set_err ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  rd_align_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (TGT_W)
  ) u_rd_align (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (rd_issue),
    .in_last_i   (last_beat),
    .in_tag_i    (tgt_q),
    .out_valid_o (pipe_valid),
    .out_last_o  (pipe_last),
    .out_tag_o   (pipe_tag),
    .inflight_o  (pipe_inflight)
  );

  generate
    for (genvar gi = 0; gi < N_TGT; gi++) begin : g_chan
      assign tgt_en[gi]     = access && (tgt_q == TGT_W'(gi));
      assign chan_rdata[gi] = tgt_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Returns tagged with an unmapped channel read back as zero.
  always_comb begin
    rdata = '0;
    if (pipe_valid && (int'(pipe_tag) < N_TGT)) begin
      rdata = chan_rdata[pipe_tag];
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign rdata_valid = pipe_valid;
  assign rdata_last  = pipe_last;
  assign tgt_we      = wr_beat;
  assign tgt_addr    = addr_q;
  assign tgt_wdata   = wr_beat ? wdata : '0;
  assign core_halt   = halt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_host_access_port.sv
// Directed bench: instance A (4 channels, 1-cycle reads) and instance B
// (3 channels, 3-cycle reads) share one command stream.
module tb_host_access_port;
  import host_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_tgt;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdata_valid;
  logic [31:0] wdata;

  logic        cmd_ready_a, wdata_ready_a, rdata_valid_a, rdata_last_a, tgt_we_a, core_halt_a, err_a;
  logic [31:0] rdata_a, tgt_addr_a, tgt_wdata_a;
  logic [3:0]  tgt_en_a;
  logic [127:0] tgt_rdata_a = '0;

  logic        cmd_ready_b, wdata_ready_b, rdata_valid_b, rdata_last_b, tgt_we_b, core_halt_b, err_b;
  logic [31:0] rdata_b, tgt_addr_b, tgt_wdata_b;
  logic [2:0]  tgt_en_b;
  logic [95:0] tgt_rdata_b;
  logic [31:0] addr_b_d1 = '0, addr_b_d2 = '0, addr_b_d3 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  host_access_port #(.ADDR_W(32), .DATA_W(32), .N_TGT(4), .RD_LAT(1), .LEN_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op),
    .cmd_tgt(cmd_tgt), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_valid(wdata_valid),
    .wdata(wdata), .wdata_ready(wdata_ready_a), .rdata_valid(rdata_valid_a), .rdata(rdata_a),
    .rdata_last(rdata_last_a), .tgt_en(tgt_en_a), .tgt_we(tgt_we_a), .tgt_addr(tgt_addr_a),
    .tgt_wdata(tgt_wdata_a), .tgt_rdata(tgt_rdata_a), .core_halt(core_halt_a), .err(err_a)
  );

  host_access_port #(.ADDR_W(32), .DATA_W(32), .N_TGT(3), .RD_LAT(3), .LEN_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op),
    .cmd_tgt(cmd_tgt), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_valid(wdata_valid),
    .wdata(wdata), .wdata_ready(wdata_ready_b), .rdata_valid(rdata_valid_b), .rdata(rdata_b),
    .rdata_last(rdata_last_b), .tgt_en(tgt_en_b), .tgt_we(tgt_we_b), .tgt_addr(tgt_addr_b),
    .tgt_wdata(tgt_wdata_b), .tgt_rdata(tgt_rdata_b), .core_halt(core_halt_b), .err(err_b)
  );

  // Target memories: channel k returns {C, k, addr[23:0]} after the read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) tgt_rdata_a[k*32 +: 32] <= {4'hC, 4'(k), tgt_addr_a[23:0]};
    addr_b_d1 <= tgt_addr_b;
    addr_b_d2 <= addr_b_d1;
    addr_b_d3 <= addr_b_d2;
  end

  always_comb begin
    tgt_rdata_b = '0;
    for (int k = 0; k < 3; k++) tgt_rdata_b[k*32 +: 32] = {4'hC, 4'(k), addr_b_d3[23:0]};
  end

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] tgt,
                          input logic [31:0] addr, input logic [3:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_tgt = tgt; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (!(cmd_ready_a && cmd_ready_b) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL %s_idle_timeout: got ready_a=%b ready_b=%b want 1 1", tag, cmd_ready_a, cmd_ready_b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      total++;
      if (cmd_ready_a !== 1'b1 || core_halt_a !== 1'b1 || tgt_en_a !== 4'b0 || tgt_we_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_a c%0d: got ready=%b halt=%b en=%b we=%b want 1 1 0000 0", c, cmd_ready_a, core_halt_a, tgt_en_a, tgt_we_a);
      end
      total++;
      if (cmd_ready_b !== 1'b1 || core_halt_b !== 1'b1 || tgt_en_b !== 3'b0 || tgt_we_b !== 1'b0) begin
        bad++;
        $display("FAIL reset_b c%0d: got ready=%b halt=%b en=%b we=%b want 1 1 000 0", c, cmd_ready_b, core_halt_b, tgt_en_b, tgt_we_b);
      end
      total++;
      if (rdata_valid_a !== 1'b0 || wdata_ready_a !== 1'b0 || err_a !== 1'b0 || rdata_last_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_misc c%0d: got rv=%b wr=%b err=%b last=%b want 0 0 0 0", c, rdata_valid_a, wdata_ready_a, err_a, rdata_last_a);
      end
    end
    total++;
    if (tgt_addr_a !== 32'h0 || tgt_wdata_a !== 32'h0 || rdata_a !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0 0 0", tgt_addr_a, tgt_wdata_a, rdata_a);
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] d;
    send_cmd(OP_WRITE, 2'd0, 32'h10, 4'd3);
    for (int i = 0; i < 4; i++) begin
      d = 32'hA0 + 32'(i);
      wdata_valid = 1'b1; wdata = d;
      #1;
      total++;
      if (tgt_en_a !== 4'b0001 || tgt_we_a !== 1'b1 || wdata_ready_a !== 1'b1) begin
        bad++;
        $display("FAIL wr_strobe beat%0d: got en=%b we=%b wready=%b want 0001 1 1", i, tgt_en_a, tgt_we_a, wdata_ready_a);
      end
      total++;
      if (tgt_addr_a !== 32'h10 + 32'(i) || tgt_wdata_a !== d) begin
        bad++;
        $display("FAIL wr_beat%0d: got addr=%h data=%h want %h %h", i, tgt_addr_a, tgt_wdata_a, 32'h10 + 32'(i), d);
      end
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1;
    total++;
    if (cmd_ready_a !== 1'b1 || tgt_en_a !== 4'b0 || core_halt_a !== 1'b1 || wdata_ready_a !== 1'b0) begin
      bad++;
      $display("FAIL wr_done: got ready=%b en=%b halt=%b wready=%b want 1 0000 1 0", cmd_ready_a, tgt_en_a, core_halt_a, wdata_ready_a);
    end
  endtask

  task automatic test_read_burst();
    logic ev;
    send_cmd(OP_READ, 2'd1, 32'h20, 4'd2);
    for (int c = 1; c <= 8; c++) begin
      #1;
      ev = (c >= 2 && c <= 4);
      total++;
      if (rdata_valid_a !== ev || rdata_last_a !== (c == 4) || cmd_ready_a !== (c >= 5)) begin
        bad++;
        $display("FAIL rd_a_ctl c%0d: got v=%b last=%b ready=%b want %b %b %b", c, rdata_valid_a, rdata_last_a, cmd_ready_a, ev, c == 4, c >= 5);
      end
      total++;
      if (tgt_en_a !== ((c <= 3) ? 4'b0010 : 4'b0000) || tgt_we_a !== 1'b0) begin
        bad++;
        $display("FAIL rd_a_issue c%0d: got en=%b we=%b", c, tgt_en_a, tgt_we_a);
      end
      if (ev) begin
        total++;
        if (rdata_a !== 32'hC1000020 + 32'(c - 2)) begin
          bad++;
          $display("FAIL rd_a_data c%0d: got %h want %h", c, rdata_a, 32'hC1000020 + 32'(c - 2));
        end
      end
      ev = (c >= 4 && c <= 6);
      total++;
      if (rdata_valid_b !== ev || rdata_last_b !== (c == 6) || cmd_ready_b !== (c >= 7)) begin
        bad++;
        $display("FAIL rd_b_ctl c%0d: got v=%b last=%b ready=%b want %b %b %b", c, rdata_valid_b, rdata_last_b, cmd_ready_b, ev, c == 6, c >= 7);
      end
      if (ev) begin
        total++;
        if (rdata_b !== 32'hC1000020 + 32'(c - 4)) begin
          bad++;
          $display("FAIL rd_b_data c%0d: got %h want %h", c, rdata_b, 32'hC1000020 + 32'(c - 4));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addr_wrap();
    wait_idle("wrap");
    send_cmd(OP_WRITE, 2'd2, 32'hFFFF_FFFF, 4'd1);
    wdata_valid = 1'b1; wdata = 32'h1111_1111;
    #1;
    total++;
    if (tgt_addr_a !== 32'hFFFF_FFFF || tgt_en_a !== 4'b0100) begin
      bad++;
      $display("FAIL wrap_beat0: got addr=%h en=%b want ffffffff 0100", tgt_addr_a, tgt_en_a);
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    total++;
    if (tgt_en_a !== 4'b0 || tgt_we_a !== 1'b0 || wdata_ready_a !== 1'b1) begin
      bad++;
      $display("FAIL wrap_gap: got en=%b we=%b wready=%b want 0000 0 1", tgt_en_a, tgt_we_a, wdata_ready_a);
    end
    @(negedge clk);
    wdata_valid = 1'b1; wdata = 32'h2222_2222;
    #1;
    total++;
    if (tgt_addr_a !== 32'h0 || tgt_wdata_a !== 32'h2222_2222 || tgt_we_a !== 1'b1) begin
      bad++;
      $display("FAIL wrap_beat1: got addr=%h data=%h we=%b want 00000000 22222222 1", tgt_addr_a, tgt_wdata_a, tgt_we_a);
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    total++;
    if (cmd_ready_a !== 1'b1 || err_a !== 1'b0 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL wrap_done: got ready=%b err_a=%b err_b=%b want 1 0 0", cmd_ready_a, err_a, err_b);
    end
  endtask

  task automatic test_bad_target();
    wait_idle("badtgt");
    // Channel 3 is the spare on A but unmapped on B.
    send_cmd(OP_READ, 2'd3, 32'h40, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      total++;
      if (tgt_en_b !== 3'b000 || err_b !== 1'b1 || err_a !== 1'b0) begin
        bad++;
        $display("FAIL bad_tgt c%0d: got en_b=%b err_b=%b err_a=%b want 000 1 0", c, tgt_en_b, err_b, err_a);
      end
      if (c == 1) begin
        total++;
        if (tgt_en_a !== 4'b1000) begin
          bad++;
          $display("FAIL spare_en: got %b want 1000", tgt_en_a);
        end
      end
      if (c == 2) begin
        total++;
        if (rdata_valid_a !== 1'b1 || rdata_a !== 32'hC300_0040 || rdata_last_a !== 1'b1) begin
          bad++;
          $display("FAIL spare_data: got v=%b d=%h last=%b want 1 c3000040 1", rdata_valid_a, rdata_a, rdata_last_a);
        end
      end
      if (c == 4) begin
        total++;
        if (rdata_valid_b !== 1'b1 || rdata_b !== 32'h0 || rdata_last_b !== 1'b1) begin
          bad++;
          $display("FAIL bad_tgt_data: got v=%b d=%h last=%b want 1 00000000 1", rdata_valid_b, rdata_b, rdata_last_b);
        end
      end
      @(negedge clk);
    end
    wait_idle("clr");
    send_cmd(OP_CTRL, 2'd0, 32'h2, 4'd0);
    #1;
    total++;
    if (err_b !== 1'b0 || core_halt_a !== 1'b0 || core_halt_b !== 1'b0) begin
      bad++;
      $display("FAIL ctrl_clear: got err_b=%b halt_a=%b halt_b=%b want 0 0 0", err_b, core_halt_a, core_halt_b);
    end
    // Stray write beat while idle flags an error on both instances.
    @(negedge clk);
    wdata_valid = 1'b1;
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    total++;
    if (err_a !== 1'b1 || err_b !== 1'b1) begin
      bad++;
      $display("FAIL stray_wdata: got err_a=%b err_b=%b want 1 1", err_a, err_b);
    end
    send_cmd(OP_CTRL, 2'd0, 32'h3, 4'd0);
    #1;
    total++;
    if (err_a !== 1'b0 || core_halt_a !== 1'b1) begin
      bad++;
      $display("FAIL ctrl_clr_halt: got err=%b halt=%b want 0 1", err_a, core_halt_a);
    end
  endtask

  task automatic test_reset_mid_read();
    wait_idle("midrd");
    send_cmd(OP_READ, 2'd1, 32'h30, 4'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (tgt_en_a !== 4'b0010 || rdata_valid_a !== 1'b1) begin
      bad++;
      $display("FAIL midrd_running: got en=%b v=%b want 0010 1", tgt_en_a, rdata_valid_a);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      #1;
      total++;
      if (rdata_valid_a !== 1'b0 || rdata_valid_b !== 1'b0 || tgt_en_a !== 4'b0 || tgt_en_b !== 3'b0) begin
        bad++;
        $display("FAIL midrd_flush c%0d: got v_a=%b v_b=%b en_a=%b en_b=%b want 0 0 0000 000", c, rdata_valid_a, rdata_valid_b, tgt_en_a, tgt_en_b);
      end
      total++;
      if (core_halt_a !== 1'b1 || cmd_ready_a !== 1'b1 || cmd_ready_b !== 1'b1) begin
        bad++;
        $display("FAIL midrd_state c%0d: got halt=%b ready_a=%b ready_b=%b want 1 1 1", c, core_halt_a, cmd_ready_a, cmd_ready_b);
      end
      @(negedge clk);
    end
    send_cmd(OP_CTRL, 2'd0, 32'h0, 4'd0);
    #1;
    total++;
    if (core_halt_a !== 1'b0 || core_halt_b !== 1'b0) begin
      bad++;
      $display("FAIL run_release: got halt_a=%b halt_b=%b want 0 0", core_halt_a, core_halt_b);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_tgt = '0; cmd_addr = '0;
    cmd_len = '0; wdata_valid = 1'b0; wdata = '0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_addr_wrap();
    test_bad_target();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
